encrypt_stream: RTL

//  Streaming, handshaked successor to the single-word integer encryptor: c = (m + r*q + s*kappa) mod N, N = q*p.

---
 rtl/encrypt_stream.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/encrypt_stream.sv
// ---------------------------------------------------------------------------
// encrypt_stream
//
// Streaming integer encryptor: c = (m + r*q + s*kappa) mod N, with N = q*p.
// A key (q, p, kappa, LFSR seed) is loaded once. N is then built by a
// sequential shift-add multiplier. Every accepted plaintext word is turned
// into a pre-reduction sum in one cycle and reduced by a restoring
// shift-subtract modulo, one sum bit per cycle, MSB first. The noise terms
// r and s are taken from an internal 64-bit Fibonacci LFSR.
//
// Ports
//   clk        in   clock, everything on the rising edge
//   reset      in   synchronous, active-low reset
//   key_valid  in   key/seed offered
//   key_ready  out  key accepted when key_valid & key_ready
//   q_param    in   modulus factor q            [Q_W]
//   p_key      in   secret p                    [P_W]
//   kappa_key  in   kappa                       [K_W]
//   seed       in   LFSR seed (0 is replaced by 1) [64]
//   noise_off  in   1: r = s = 0 for the accepted message
//   in_valid   in   plaintext offered
//   in_ready   out  plaintext accepted when in_valid & in_ready
//   m          in   plaintext                   [M_W]
//   c_valid    out  ciphertext valid
//   c_ready    in   sink takes c when c_valid & c_ready
//   c          out  ciphertext                  [Q_W+P_W]
//   key_err    out  last loaded key gave N == 0
//   busy       out  state is KEYGEN, SUM, REDUCE or DONE
// ---------------------------------------------------------------------------
module encrypt_stream #(
    parameter int M_W = 32,
    parameter int Q_W = 64,
    parameter int P_W = 64,
    parameter int K_W = 16,
    parameter int R_W = 24,
    parameter int S_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 key_valid,
    output logic                 key_ready,
    input  logic [Q_W-1:0]       q_param,
    input  logic [P_W-1:0]       p_key,
    input  logic [K_W-1:0]       kappa_key,
    input  logic [63:0]          seed,
    input  logic                 noise_off,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [M_W-1:0]       m,
    output logic                 c_valid,
    input  logic                 c_ready,
    output logic [Q_W+P_W-1:0]   c,
    output logic                 key_err,
    output logic                 busy
);

    localparam int N_W     = Q_W + P_W;
    localparam int RQ_W    = R_W + Q_W;
    localparam int SK_W    = S_W + K_W;
    localparam int MAX1    = (M_W > RQ_W) ? M_W : RQ_W;
    localparam int MAX2    = (MAX1 > SK_W) ? MAX1 : SK_W;
    localparam int SUM_W   = MAX2 + 2;
    localparam int CNT_MAX = (P_W > SUM_W) ? P_W : SUM_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        KEYGEN,
        READY,
        SUM,
        REDUCE,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [Q_W-1:0]       qReg_q, qReg_d;
    logic [P_W-1:0]       pShift_q, pShift_d;
    logic [K_W-1:0]       kappa_q, kappa_d;
    logic [N_W-1:0]       qShift_q, qShift_d;
    logic [N_W-1:0]       nMod_q, nMod_d;
    logic [63:0]          lfsr_q, lfsr_d;
    logic [M_W-1:0]       mReg_q, mReg_d;
    logic [R_W-1:0]       rReg_q, rReg_d;
    logic [S_W-1:0]       sReg_q, sReg_d;
    logic [SUM_W-1:0]     sum_q, sum_d;
    logic [N_W-1:0]       rem_q, rem_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_W-1:0]       c_q, c_d;
    logic                 cValid_q, cValid_d;
    logic                 keyErr_q, keyErr_d;

    logic                 keyReady;
    logic                 inReady;
    logic                 keyAccept;
    logic                 msgAccept;
    logic                 lfsrFb;
    logic [N_W-1:0]       nAdd;
    logic [RQ_W-1:0]      rqProd;
    logic [SK_W-1:0]      skProd;
    logic [SUM_W-1:0]     sumCalc;
    logic [N_W:0]         remShift;
    logic                 remGeq;
    logic [N_W-1:0]       remSub;
    logic [N_W-1:0]       remNext;

    // Next-state, datapath next values and handshake outputs.
    always_comb begin
        state_d  = state_q;
        qReg_d   = qReg_q;
        pShift_d = pShift_q;
        kappa_d  = kappa_q;
        qShift_d = qShift_q;
        nMod_d   = nMod_q;
        lfsr_d   = lfsr_q;
        mReg_d   = mReg_q;
        rReg_d   = rReg_q;
        sReg_d   = sReg_q;
        sum_d    = sum_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        cValid_d = cValid_q;
        keyErr_d = keyErr_q;

        keyReady  = (state_q == IDLE) || (state_q == READY);
        // A pending key takes priority over a message in READY.
        inReady   = (state_q == READY) && !key_valid;
        keyAccept = key_valid && keyReady;
        msgAccept = in_valid && inReady;

        lfsrFb  = lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59];

        // One partial product per cycle: add q << i when p bit i is set.
        nAdd    = nMod_q + (pShift_q[0] ? qShift_q : '0);

        rqProd  = RQ_W'(rReg_q) * RQ_W'(qReg_q);
        skProd  = SK_W'(sReg_q) * SK_W'(kappa_q);
        sumCalc = SUM_W'(mReg_q) + SUM_W'(rqProd) + SUM_W'(skProd);

        // Restoring step: the remainder stays below N, so after the shift
        // the difference always fits back into N_W bits.
        remShift = {rem_q, sum_q[SUM_W-1]};
        remGeq   = remShift >= {1'b0, nMod_q};
        remSub   = remShift[N_W-1:0] - nMod_q;
        remNext  = remGeq ? remSub : remShift[N_W-1:0];

        case (state_q)
            IDLE, READY: begin
                if (keyAccept) begin
                    qReg_d   = q_param;
                    pShift_d = p_key;
                    kappa_d  = kappa_key;
                    qShift_d = N_W'(q_param);
                    nMod_d   = '0;
                    cnt_d    = '0;
                    lfsr_d   = (seed == 64'h0) ? 64'h1 : seed;
                    state_d  = KEYGEN;
                end else if (msgAccept) begin
                    mReg_d  = m;
                    rReg_d  = noise_off ? '0 : lfsr_q[R_W-1:0];
                    sReg_d  = noise_off ? '0 : lfsr_q[R_W+S_W-1:R_W];
                    state_d = SUM;
                end
            end
            KEYGEN: begin
                nMod_d   = nAdd;
                pShift_d = pShift_q >> 1;
                qShift_d = qShift_q << 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(P_W - 1)) begin
                    cnt_d    = '0;
                    keyErr_d = (nAdd == '0);
                    state_d  = (nAdd == '0) ? IDLE : READY;
                end
            end
            SUM: begin
                sum_d   = sumCalc;
                lfsr_d  = {lfsr_q[62:0], lfsrFb};
                rem_d   = '0;
                cnt_d   = '0;
                state_d = REDUCE;
            end
            REDUCE: begin
                rem_d = remNext;
                sum_d = sum_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(SUM_W - 1)) begin
                    cnt_d    = '0;
                    c_d      = remNext;
                    cValid_d = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (c_ready) begin
                    cValid_d = 1'b0;
                    state_d  = READY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            qReg_q   <= '0;
            pShift_q <= '0;
            kappa_q  <= '0;
            qShift_q <= '0;
            nMod_q   <= '0;
            lfsr_q   <= 64'h1;
            mReg_q   <= '0;
            rReg_q   <= '0;
            sReg_q   <= '0;
            sum_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            c_q      <= '0;
            cValid_q <= 1'b0;
            keyErr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            qReg_q   <= qReg_d;
            pShift_q <= pShift_d;
            kappa_q  <= kappa_d;
            qShift_q <= qShift_d;
            nMod_q   <= nMod_d;
            lfsr_q   <= lfsr_d;
            mReg_q   <= mReg_d;
            rReg_q   <= rReg_d;
            sReg_q   <= sReg_d;
            sum_q    <= sum_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            cValid_q <= cValid_d;
            keyErr_q <= keyErr_d;
        end
    end

    assign key_ready = keyReady;
    assign in_ready  = inReady;
    assign c_valid   = cValid_q;
    assign c         = c_q;
    assign key_err   = keyErr_q;
    assign busy      = (state_q == KEYGEN) || (state_q == SUM) ||
                       (state_q == REDUCE) || (state_q == DONE);

endmodule
